hams_mele_pack: RTL and testbench

Stream-to-block packer on the input side of the M-element sorter. It accepts one `pair` per cycle on a valid/ready stream and assembles groups of NUM_ELEMENTS into a parallel block. It presents each block with a block-level valid/ready handshake, the count of real elements, and a last flag. A two-slot (fill + output) buffer lets the next block fill while the current one waits for downstream acceptance.

---
 rtl/hams_mele_pack_if.sv | 34 +++
 rtl/hams_mele_pack.sv | 102 ++++++++++
 tb/tb_hams_mele_pack.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/hams_mele_pack_if.sv
// Element type package and stream/block handshake interface for hams_mele_pack.
// Compiled before rtl/hams_mele_pack.sv.
package hams_pkg;
  typedef struct packed {
    logic [15:0] key;
    logic [15:0] tag;
  } pair;
endpackage

interface hams_mele_pack_if #(
  parameter int unsigned NUM_ELEMENTS = 8
);
  localparam int unsigned CNT_W = $clog2(NUM_ELEMENTS + 1);

  hams_pkg::pair                    in_data;
  logic                             in_valid;
  logic                             in_last;
  logic                             in_ready;
  hams_pkg::pair [NUM_ELEMENTS-1:0] blk_data;
  logic                             blk_valid;
  logic                             blk_ready;
  logic [CNT_W-1:0]                 blk_count;
  logic                             blk_last;

  modport master (
    output in_data, in_valid, in_last, blk_ready,
    input  in_ready, blk_data, blk_valid, blk_count, blk_last
  );

  modport slave (
    input  in_data, in_valid, in_last, blk_ready,
    output in_ready, blk_data, blk_valid, blk_count, blk_last
  );
endinterface

// File: rtl/hams_mele_pack.sv
// Stream-to-block packer with a fill slot and an output slot.
// Define HAMS_PACK_PAD_EN to pad partial blocks with all-ones instead of zeros.
module hams_mele_pack #(
  parameter int unsigned NUM_ELEMENTS = 8
) (
  input logic              clk,
  input logic              rst_n,
  hams_mele_pack_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(NUM_ELEMENTS + 1);

`ifdef HAMS_PACK_PAD_EN
  localparam hams_pkg::pair PAD = '1;
`else
  localparam hams_pkg::pair PAD = '0;
`endif

  logic [CNT_W-1:0]                 cnt;
  logic                             pending;
  hams_pkg::pair [NUM_ELEMENTS-1:0] f_data;
  logic [CNT_W-1:0]                 f_count;
  logic                             f_last;
  hams_pkg::pair [NUM_ELEMENTS-1:0] o_data;
  logic                             o_valid;
  logic [CNT_W-1:0]                 o_count;
  logic                             o_last;

  logic                             accept;
  logic                             complete;
  logic                             drain;
  hams_pkg::pair [NUM_ELEMENTS-1:0] done_blk;
  logic [CNT_W-1:0]                 done_count;

  assign accept     = bus.in_valid && !pending;
  assign complete   = accept && (cnt == CNT_W'(NUM_ELEMENTS - 1) || bus.in_last);
  assign drain      = o_valid && bus.blk_ready;
  assign done_count = cnt + CNT_W'(1);

  // Completed block view: filled slots, the element being accepted, then pads.
  // Slots past cnt may hold stale data from an earlier block, so pad by index.
  always_comb begin
    done_blk = '0;
    for (int unsigned k = 0; k < NUM_ELEMENTS; k++) begin
      if (k < 32'(cnt))       done_blk[k] = f_data[k];
      else if (k == 32'(cnt)) done_blk[k] = bus.in_data;
      else                    done_blk[k] = PAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      pending <= 1'b0;
      f_data  <= '0;
      f_count <= '0;
      f_last  <= 1'b0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_count <= '0;
      o_last  <= 1'b0;
    end else begin
      if (accept) begin
        if (complete) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
          for (int unsigned k = 0; k < NUM_ELEMENTS; k++) begin
            if (k == 32'(cnt)) f_data[k] <= bus.in_data;
          end
        end
      end

      if (complete) begin
        if (!o_valid || drain) begin
          o_data  <= done_blk;
          o_count <= done_count;
          o_last  <= bus.in_last;
          o_valid <= 1'b1;
        end else begin
          f_data  <= done_blk;
          f_count <= done_count;
          f_last  <= bus.in_last;
          pending <= 1'b1;
        end
      end else if (pending && drain) begin
        o_data  <= f_data;
        o_count <= f_count;
        o_last  <= f_last;
        o_valid <= 1'b1;
        pending <= 1'b0;
      end else if (drain) begin
        o_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = !pending;
  assign bus.blk_data  = o_data;
  assign bus.blk_valid = o_valid;
  assign bus.blk_count = o_count;
  assign bus.blk_last  = o_last;
endmodule

// File: tb/tb_hams_mele_pack.sv
// Directed self-checking bench for hams_mele_pack (NUM_ELEMENTS = 8).
module tb_hams_mele_pack;
  localparam int unsigned NE = 8;
  localparam int unsigned PW = $bits(hams_pkg::pair);
  localparam int unsigned BW = NE * PW;

`ifdef HAMS_PACK_PAD_EN
  localparam logic [PW-1:0] PADV = '1;
`else
  localparam logic [PW-1:0] PADV = '0;
`endif

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  hams_mele_pack_if #(.NUM_ELEMENTS(NE)) bus ();

  hams_mele_pack #(.NUM_ELEMENTS(NE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] exp_blk(input int base, input int n);
    logic [BW-1:0] v;
    v = '0;
    for (int k = 0; k < int'(NE); k++)
      v[k*PW +: PW] = (k < n) ? PW'(base + k) : PADV;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Presents one element for one clock edge; caller ensures in_ready is high.
  task automatic send(input int v, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = hams_pkg::pair'(PW'(v));
    bus.in_last  = last;
    step();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic chk_blk(input string tag, input int base, input int n, input logic last);
    chk({tag, "_valid"}, BW'(bus.blk_valid), BW'(1'b1));
    chk({tag, "_data"},  bus.blk_data,       exp_blk(base, n));
    chk({tag, "_count"}, BW'(bus.blk_count), BW'(n));
    chk({tag, "_last"},  BW'(bus.blk_last),  BW'(last));
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_data   = '0;
    bus.blk_ready = 1'b0;
    step();
    step();
    chk("rst_valid", BW'(bus.blk_valid), '0);
    chk("rst_data",  bus.blk_data,       '0);
    chk("rst_count", BW'(bus.blk_count), '0);
    chk("rst_last",  BW'(bus.blk_last),  '0);
    chk("rst_ready", BW'(bus.in_ready),  BW'(1'b1));
    rst_n = 1'b1;
    step();

    // Full block streamed with downstream always ready
    bus.blk_ready = 1'b1;
    for (int i = 0; i < 7; i++) send(i, 1'b0);
    chk("full_novalid_early", BW'(bus.blk_valid), '0);
    send(7, 1'b0);
    chk_blk("full", 0, 8, 1'b0);
    step();
    chk("full_onecycle", BW'(bus.blk_valid), '0);

    // Partial block closed by in_last, then single-element block from slot 0
    send(20, 1'b0);
    send(21, 1'b0);
    send(22, 1'b1);
    chk_blk("part", 20, 3, 1'b1);
    step();
    send(30, 1'b1);
    chk_blk("single", 30, 1, 1'b1);
    step();

    // in_last on the eighth element: one full block flagged last
    for (int i = 0; i < 7; i++) send(80 + i, 1'b0);
    send(87, 1'b1);
    chk_blk("fulllast", 80, 8, 1'b1);
    step();
    chk("fulllast_noextra", BW'(bus.blk_valid), '0);

    // Backpressure: A held in output slot, B fills and stalls the input
    bus.blk_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(40 + i, 1'b0);
    for (int i = 0; i < 7; i++) send(50 + i, 1'b0);
    chk("bp_ready_before16", BW'(bus.in_ready), BW'(1'b1));
    send(57, 1'b0);
    chk("bp_ready_low", BW'(bus.in_ready), '0);
    chk_blk("bp_A_held", 40, 8, 1'b0);
    step();
    chk("bp_A_stable", bus.blk_data, exp_blk(40, 8));
    bus.blk_ready = 1'b1;
    step();
    bus.blk_ready = 1'b0;
    chk_blk("bp_B", 50, 8, 1'b0);
    chk("bp_ready_back", BW'(bus.in_ready), BW'(1'b1));
    bus.blk_ready = 1'b1;
    step();
    chk("bp_drained", BW'(bus.blk_valid), '0);

    // Output drains on the same edge the next block completes
    bus.blk_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(60 + i, 1'b0);
    for (int i = 0; i < 7; i++) send(70 + i, 1'b0);
    chk("sim_A", bus.blk_data, exp_blk(60, 8));
    bus.blk_ready = 1'b1;
    send(77, 1'b0);
    chk_blk("sim_B", 70, 8, 1'b0);
    chk("sim_no_pending", BW'(bus.in_ready), BW'(1'b1));
    step();
    chk("sim_drained", BW'(bus.blk_valid), '0);

    // Reset with a held block and a partial fill in progress
    bus.blk_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(100 + i, 1'b0);
    for (int i = 0; i < 5; i++) send(110 + i, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", BW'(bus.blk_valid), '0);
    chk("mrst_data",  bus.blk_data,       '0);
    chk("mrst_count", BW'(bus.blk_count), '0);
    chk("mrst_last",  BW'(bus.blk_last),  '0);
    chk("mrst_ready", BW'(bus.in_ready),  BW'(1'b1));
    step();
    rst_n = 1'b1;
    bus.blk_ready = 1'b1;
    step();
    for (int i = 0; i < 8; i++) send(10 + i, 1'b0);
    chk_blk("post_rst", 10, 8, 1'b0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
